fancy_timer: RTL and testbench
==============================

Name: fancy_timer

Overview:
- Serial-triggered one-shot timer.
- Watches a 1-bit `data` stream for the start pattern 1101, then shifts in a 4-bit delay value (MSB first).
- Counts for (delay+1)×1000 clock cycles, then asserts `done` until the user acknowledges with `ack`, and re-arms.
- Stand-alone control block; `count` exposes the remaining delay units while timing.

Parameters:
- CYCLES_PER_UNIT, 1000, clock cycles per delay unit; the fixed default is required.
- DELAY_W, 4, width of the delay field and of `count`.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data  input  1  serial input: start pattern and delay bits
- ack  input  1  acknowledge; releases `done` state
- count  output  4  current remaining-delay register
- counting  output  1  high while timing
- done  output  1  high after timing completes, until acked

Behaviour:
- Moore FSM, 10 states: IDLE, S1, S11, S110, B3, B2, B1, B0, COUNT, WAIT.
- Synchronous reset: state=IDLE, delay register=0, unit counter=0. Reset has priority over everything and aborts any state, including mid-shift, COUNT and WAIT.
- Pattern search (overlapping):
  - IDLE: data=1 -> S1, else IDLE.
  - S1: data=1 -> S11, else IDLE.
  - S11: data=1 -> S11, else S110.
  - S110: data=1 -> B3, else IDLE.
- Delay shift-in, one bit per cycle:
  - In B3 sample data into delay[3]; B2 -> delay[2]; B1 -> delay[1]; B0 -> delay[0].
  - Transitions are unconditional: B3->B2->B1->B0->COUNT.
  - The first delay bit is the `data` bit on the cycle immediately after the final '1' of 1101.
- COUNT:
  - Unit counter (10 bits) increments every cycle from 0.
  - On unit counter = CYCLES_PER_UNIT-1: the counter clears to 0.
    - If delay=0: go to WAIT.
    - Otherwise: delay decrements by 1 and the FSM stays in COUNT.
  - COUNT therefore lasts exactly (delay+1)×1000 cycles.
  - The unit counter is 0 on every entry to COUNT (cleared on exit and at reset).
- WAIT: ack=1 -> IDLE, else WAIT. `ack` is ignored in all other states; `data` is ignored in B*, COUNT and WAIT.
- After WAIT->IDLE the search restarts fresh; the `data` bit sampled on the ack cycle is not part of a new pattern.
- Outputs (registered state decode, no combinational input paths):
  - counting = (state==COUNT).
  - done = (state==WAIT).
  - count = delay register at all times. Only meaningful while counting=1; then it shows the remaining units (delay, delay-1, ..., 0).
- Delay register holds its value outside B* and COUNT. At COUNT exit it remains 0.
- No other outputs; count width fixed at 4.

Test Plan:
- Reset, then data 1,1,0,1,0,0,0,1 on consecutive cycles:
  - counting rises the cycle after the last delay bit is sampled.
  - count=1 for 1000 cycles, then count=0 for 1000 cycles; counting high for exactly 2000 cycles.
  - Then done=1, counting=0.
- Hold ack=0 in WAIT for 3 cycles -> done stays 1. Assert ack=1 for 1 cycle -> done=0 the next cycle, FSM in IDLE.
- After the ack, data 1,1,0,1,1,1,1,1 -> delay=15; counting high for 16000 cycles; count steps 15 down to 0 every 1000 cycles; then done=1.
- Overlap check: data 1,1,1,0,1 then 0,0,0,0 -> pattern detected, delay=0, counting for exactly 1000 cycles.
- Near-miss patterns 1,0,1,1,0,0 and 1,1,0,0 -> no detection, counting stays 0.
- Assert reset mid-COUNT and mid-WAIT -> next cycle counting=0, done=0, count=0. A subsequent 1101+delay sequence times correctly from a zeroed unit counter.

Source files
------------

// File: rtl/fancy_timer.sv
// Serial-triggered one-shot timer: detects 1101 on `data`, shifts in a 4-bit delay,
// times (delay+1) units of CYCLES_PER_UNIT cycles, then holds `done` until `ack`.
module fancy_timer #(
    parameter int CYCLES_PER_UNIT = 1000,
    parameter int DELAY_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic [DELAY_W-1:0] count,
    output logic               counting,
    output logic               done
);

    localparam int UNIT_W = 10;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(CYCLES_PER_UNIT - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        S1    = 4'd1,
        S11   = 4'd2,
        S110  = 4'd3,
        B3    = 4'd4,
        B2    = 4'd5,
        B1    = 4'd6,
        B0    = 4'd7,
        COUNT = 4'd8,
        WAIT  = 4'd9
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DELAY_W-1:0]  delay_r;
    logic [DELAY_W-1:0]  delay_s;
    logic [UNIT_W-1:0]   unit_r;
    logic [UNIT_W-1:0]   unit_s;
    logic                counting_r;
    logic                done_r;

    // Next-state, delay shift-in and unit-counter logic.
    always_comb begin
        state_s = state_r;
        delay_s = delay_r;
        unit_s  = {UNIT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (data) state_s = S1;
                else      state_s = IDLE;
            end
            S1: begin
                if (data) state_s = S11;
                else      state_s = IDLE;
            end
            S11: begin
                if (data) state_s = S11;
                else      state_s = S110;
            end
            S110: begin
                if (data) state_s = B3;
                else      state_s = IDLE;
            end
            B3: begin
                delay_s[DELAY_W-1] = data;
                state_s            = B2;
            end
            B2: begin
                delay_s[DELAY_W-2] = data;
                state_s            = B1;
            end
            B1: begin
                delay_s[DELAY_W-3] = data;
                state_s            = B0;
            end
            B0: begin
                delay_s[DELAY_W-4] = data;
                state_s            = COUNT;
            end
            COUNT: begin
                // The unit counter wraps to zero on every unit boundary, so it is
                // already zero when COUNT is left and on the next entry.
                if (unit_r == UNIT_LAST) begin
                    unit_s = {UNIT_W{1'b0}};
                    if (delay_r == {DELAY_W{1'b0}}) begin
                        state_s = WAIT;
                    end else begin
                        delay_s = delay_r - DELAY_W'(1);
                        state_s = COUNT;
                    end
                end else begin
                    unit_s  = unit_r + UNIT_W'(1);
                    state_s = COUNT;
                end
            end
            WAIT: begin
                if (ack) state_s = IDLE;
                else     state_s = WAIT;
            end
            default: begin
                state_s = IDLE;
                delay_s = {DELAY_W{1'b0}};
            end
        endcase
    end

    // State, delay, unit counter and decoded status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            delay_r    <= {DELAY_W{1'b0}};
            unit_r     <= {UNIT_W{1'b0}};
            counting_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            delay_r    <= delay_s;
            unit_r     <= unit_s;
            counting_r <= (state_s == COUNT);
            done_r     <= (state_s == WAIT);
        end
    end

    assign count    = delay_r;
    assign counting = counting_r;
    assign done     = done_r;

endmodule

// File: tb/tb_fancy_timer.sv
// Scoreboard bench for fancy_timer: stimulus queues expected output-change events,
// a negedge monitor pops and compares them whenever the outputs change.
module tb_fancy_timer;

    logic       clk;
    logic       reset;
    logic       data;
    logic       ack;
    logic [3:0] count;
    logic       counting;
    logic       done;

    fancy_timer dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .ack      (ack),
        .count    (count),
        .counting (counting),
        .done     (done)
    );

    typedef struct {
        int         cyc;
        logic       c;
        logic       d;
        logic [3:0] n;
    } ev_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   last_edge = 0;
    int   t0 = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic mon_en = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_c, prev_d;
    logic [3:0] prev_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // An event is any change of counting/done, or of count while counting.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!prev_valid || counting !== prev_c || done !== prev_d ||
                (counting === 1'b1 && count !== prev_n)) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: got cyc=%0d counting=%b done=%b count=%0d, required no event",
                             cyc, counting, done, count);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.c !== counting || e.d !== done || e.n !== count) begin
                        mismatched++;
                        $display("FAIL event: got cyc=%0d counting=%b done=%b count=%0d, required cyc=%0d counting=%b done=%b count=%0d",
                                 cyc, counting, done, count, e.cyc, e.c, e.d, e.n);
                    end
                end
            end
            prev_valid = 1'b1;
            prev_c     = counting;
            prev_d     = done;
            prev_n     = count;
        end
    end

    task automatic drive(input logic d, input logic a, input logic r);
        @(negedge clk);
        data      = d;
        ack       = a;
        reset     = r;
        last_edge = cyc + 1;
    endtask

    task automatic push(input int c, input logic cn, input logic dn, input logic [3:0] n);
        ev_t e;
        e.cyc = c;
        e.c   = cn;
        e.d   = dn;
        e.n   = n;
        sb.push_back(e);
    endtask

    task automatic start(input logic [3:0] dly);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) drive(dly[i], 1'b0, 1'b0);
        t0 = last_edge;
        push(t0, 1'b1, 1'b0, dly);
    endtask

    task automatic finish(input logic [3:0] dly, input logic use_reset);
        for (int k = 1; k <= int'(dly); k++)
            push(t0 + 1000 * k, 1'b1, 1'b0, 4'(int'(dly) - k));
        push(t0 + 1000 * (int'(dly) + 1), 1'b0, 1'b1, 4'd0);
        repeat (1000 * (int'(dly) + 1)) drive(1'($urandom_range(1, 0)), 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        if (use_reset) drive(1'b0, 1'b0, 1'b1);
        else           drive(1'b1, 1'b1, 1'b0);
        push(last_edge, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit [9:0] near_miss;
        near_miss = 10'b1011001100;
        data  = 1'b0;
        ack   = 1'b0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        push(last_edge, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        start(4'd1);
        finish(4'd1, 1'b0);

        start(4'd15);
        finish(4'd15, 1'b0);

        // Overlapping start: 1,1,1,0,1 then delay 0000.
        drive(1'b1, 1'b0, 1'b0);
        start(4'd0);
        finish(4'd0, 1'b0);

        for (int i = 9; i >= 0; i--) drive(near_miss[i], 1'b0, 1'b0);
        repeat (20) drive(1'b0, 1'b0, 1'b0);

        // Reset halfway through a unit of COUNT.
        start(4'd3);
        push(t0 + 1000, 1'b1, 1'b0, 4'd2);
        repeat (1500) drive(1'($urandom_range(1, 0)), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        push(last_edge, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0);

        start(4'd2);
        finish(4'd2, 1'b1);

        start(4'd0);
        finish(4'd0, 1'b0);

        repeat (5) drive(1'b0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            ev_t e;
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_event: got none, required cyc=%0d counting=%b done=%b count=%0d",
                     e.cyc, e.c, e.d, e.n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
